// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DIVZ
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Mult: {partial product high half, remaining multiplier bits}.
  // Div: low half holds dividend bits shifting out / quotient bits shifting in.
  // Divide-by-zero: low half holds the raw dividend for the HI commit.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Partial remainder; the extra bit of the trial subtraction lives in rem_sh.
  logic [WIDTH-1:0]   rem_q, rem_d;
  // Multiplicand for mult, divisor for div (magnitudes for signed ops).
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_md;
  logic               op_div;
  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  assign is_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy | (start & is_md);

  // Next-state, datapath iteration and HI/LO commit decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    rem_sh  = {rem_q, acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb_q};
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opb_q} & {(WIDTH+1){acc_q[0]}});
    product = neg_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_md) begin
            is_div_d  = op_div;
            neg_d     = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = op_signed & a[WIDTH-1];
            cnt_d     = CW'(WIDTH);
            rem_d     = '0;
            if (op_div && (b == '0)) begin
              acc_d   = {{WIDTH{1'b0}}, a};
              state_d = S_DIVZ;
            end else if (op_div) begin
              acc_d   = {{WIDTH{1'b0}}, abs_a};
              opb_d   = abs_b;
              state_d = S_RUN;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, abs_b};
              opb_d   = abs_a;
              state_d = S_RUN;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            rem_d              = diff[WIDTH-1:0];
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d              = rem_sh[WIDTH-1:0];
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DIVZ: begin
        lo_d    = '1;
        hi_d    = acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .stall (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural result plus remaining busy cycles
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  int          m_left = 0;
  logic        m_done = 1'b0;

  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] qx, qy;
    logic [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    qx = x;
    qy = y;
    r = '0;
    case (o)
      3'd1: r = sx * sy;
      3'd2: r = {32'd0, x} * {32'd0, y};
      3'd3: begin
        if (y == 0)                                   r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == '1)        r = {32'd0, 32'h80000000};
        else                                          r = {32'(qx % qy), 32'(qx / qy)};
      end
      3'd4: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else        r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    logic [63:0] res;
    m_done = 1'b0;
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
        m_done = 1'b1;
      end
    end else if (start) begin
      if (op >= 3'd1 && op <= 3'd4) begin
        res = model_result(op, a, b);
        p_hi = res[63:32];
        p_lo = res[31:0];
        m_left = ((op == 3'd3 || op == 3'd4) && b == 0) ? 1 : 33;
      end else if (op == 3'd5) begin
        m_hi = a;
      end else if (op == 3'd6) begin
        m_lo = a;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
      chk("stall", {63'd0, stall}, {63'd0, ((m_left > 0) || (start && op >= 3'd1 && op <= 3'd4))});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    step();
    start = 1'b0;
    op = 3'd0;
  endtask

  task automatic wait_done(input bit interfere, output int bc);
    int cycles;
    cycles = 0;
    bc = 0;
    while (!done && cycles < 100) begin
      if (busy) bc++;
      if (interfere && cycles == 5) begin
        start = 1'b1;
        op = 3'($urandom_range(1, 6));
        a = $urandom;
        b = $urandom;
      end
      step();
      start = 1'b0;
      cycles++;
    end
    chk("done_timeout", {63'd0, done}, 64'd1);
  endtask

  function automatic logic [31:0] pick_val(input bit allow_zero);
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return allow_zero ? 32'd0 : 32'd1;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    reset = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    step();
    step();
    chk_en = 1'b1;
    reset = 1'b0;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1'b0, bc);
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_hi", {32'd0, hi}, 64'hFFFFFFFE);
    chk("multu_lo", {32'd0, lo}, 64'h00000001);

    issue(3'd1, 32'hFFFFFFFD, 32'd5);
    wait_done(1'b0, bc);
    chk("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFFFFF1);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0, bc);
    chk("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFFFFFF);

    issue(3'd4, 32'h12345678, 32'd0);
    wait_done(1'b0, bc);
    chk("divz_busy_cycles", 64'(bc), 64'd1);
    chk("divz_lo", {32'd0, lo}, 64'hFFFFFFFF);
    chk("divz_hi", {32'd0, hi}, 64'h12345678);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0, bc);
    chk("ovf_lo", {32'd0, lo}, 64'h80000000);
    chk("ovf_hi", {32'd0, hi}, 64'd0);

    issue(3'd5, 32'hDEADBEEF, 32'd0);
    chk("mthi_hi", {32'd0, hi}, 64'hDEADBEEF);
    issue(3'd6, 32'hCAFEF00D, 32'd0);
    chk("mtlo_lo", {32'd0, lo}, 64'hCAFEF00D);
    chk("mt_busy", {63'd0, busy}, 64'd0);

    issue(3'd4, 32'd100, 32'd7);
    repeat (9) step();
    start = 1'b1; op = 3'd2; a = 32'd3; b = 32'd3;
    step();
    op = 3'd6; a = 32'd99;
    step();
    start = 1'b0; op = 3'd0;
    wait_done(1'b0, bc);
    chk("ignored_lo", {32'd0, lo}, 64'd14);
    chk("ignored_hi", {32'd0, hi}, 64'd2);

    issue(3'd5, 32'h55555555, 32'd0);
    issue(3'd6, 32'h55555555, 32'd0);
    issue(3'd1, 32'd6, 32'd7);
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (40) step();
    issue(3'd2, 32'd6, 32'd7);
    wait_done(1'b0, bc);
    chk("after_abort_lo", {32'd0, lo}, 64'd42);
    chk("after_abort_hi", {32'd0, hi}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      issue(o, pick_val(1'b1), pick_val($urandom_range(0, 3) == 0));
      if (o >= 3'd1 && o <= 3'd4) begin
        wait_done($urandom_range(0, 1) == 1, bc);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
